// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, response FSM state type and the control-code legality check
package alu_pkg;
  localparam int ALU_CTRL_W = 4;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b1101;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_PASS = 4'b1111;
  typedef enum logic {EMPTY, FULL} rsp_state_e;
  function automatic logic is_legal_ctrl(input logic [ALU_CTRL_W-1:0] c);
    return c inside {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
                     ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS};
  endfunction
endpackage

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: two request ports, ALU drive/result and response port; slave = arbiter side, master = environment side
interface alu_share_arb_if #(parameter int TAG_W = 4, parameter int DATA_W = 32);
  import alu_pkg::*;
  logic                  req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DATA_W-1:0]     req0_rs1, req0_op2, req1_rs1, req1_op2;
  logic [ALU_CTRL_W-1:0] req0_ctrl, req1_ctrl;
  logic [TAG_W-1:0]      req0_tag, req1_tag;
  logic [DATA_W-1:0]     alu_rs1, alu_op2, alu_data;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [DATA_W-1:0]     rsp_data;
  logic [TAG_W-1:0]      rsp_tag;
  modport slave (
    input  req0_valid, req0_rs1, req0_op2, req0_ctrl, req0_tag,
    input  req1_valid, req1_rs1, req1_op2, req1_ctrl, req1_tag,
    input  alu_data, rsp_ready,
    output req0_ready, req1_ready, alu_rs1, alu_op2, alu_ctrl,
    output rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_err
  );
  modport master (
    output req0_valid, req0_rs1, req0_op2, req0_ctrl, req0_tag,
    output req1_valid, req1_rs1, req1_op2, req1_ctrl, req1_tag,
    output alu_data, rsp_ready,
    input  req0_ready, req1_ready, alu_rs1, alu_op2, alu_ctrl,
    input  rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_err
  );
endinterface

// File: rtl/alu_share_arb_rr_arb2.sv
// rr_arb2: two-way round-robin grant; ports valid0/valid1/last_gnt in, gnt_valid/gnt_id out
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_id
);
  assign gnt_valid = valid0 | valid1;
  assign gnt_id = (valid0 & valid1) ? ~last_gnt : valid1;
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin share of one ALU between two requesters with a one-entry response buffer; ports clk, rst, bus (slave)
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input logic            clk,
  input logic            rst,
  alu_share_arb_if.slave bus
);
  rsp_state_e            state_q, state_d;
  logic                  last_gnt_q, last_gnt_d, rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]     rsp_data_q, rsp_data_d, sel_rs1, sel_op2;
  logic [TAG_W-1:0]      rsp_tag_q, rsp_tag_d, sel_tag;
  logic [ALU_CTRL_W-1:0] sel_ctrl;
  logic                  gnt_valid, gnt_id, can_accept, accept, legal;
  rr_arb2 u_arb (
    .valid0   (bus.req0_valid),
    .valid1   (bus.req1_valid),
    .last_gnt (last_gnt_q),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );
  always_comb begin
    sel_rs1    = gnt_id ? bus.req1_rs1 : bus.req0_rs1;
    sel_op2    = gnt_id ? bus.req1_op2 : bus.req0_op2;
    sel_ctrl   = gnt_id ? bus.req1_ctrl : bus.req0_ctrl;
    sel_tag    = gnt_id ? bus.req1_tag : bus.req0_tag;
    legal      = is_legal_ctrl(sel_ctrl);
    can_accept = (state_q == EMPTY) || bus.rsp_ready;
    accept     = gnt_valid && can_accept;
    state_d    = accept ? FULL : bus.rsp_ready ? EMPTY : state_q;
    last_gnt_d = accept ? gnt_id : last_gnt_q;
    rsp_data_d = accept ? (legal ? bus.alu_data : '0) : rsp_data_q;
    rsp_id_d   = accept ? gnt_id : rsp_id_q;
    rsp_tag_d  = accept ? sel_tag : rsp_tag_q;
    rsp_err_d  = accept ? !legal : rsp_err_q;
  end
  // illegal codes become "pass 0" so the ALU never sees an undefined control
  assign bus.alu_rs1    = gnt_valid ? sel_rs1 : '0;
  assign bus.alu_op2    = (gnt_valid && legal) ? sel_op2 : '0;
  assign bus.alu_ctrl   = !gnt_valid ? ALU_ADD : legal ? sel_ctrl : ALU_PASS;
  assign bus.req0_ready = accept && !gnt_id;
  assign bus.req1_ready = accept && gnt_id;
  assign bus.rsp_valid  = state_q == FULL;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_err    = rsp_err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      last_gnt_q <= 1'b1;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_err_q  <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed scoreboard bench for alu_share_arb with a behavioural ALU
module tb_alu_share_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  typedef struct packed {
    logic [31:0] data;
    logic        id;
    logic [3:0]  tag;
    logic        err;
  } exp_t;
  exp_t q[$];
  alu_share_arb_if #(.TAG_W(4), .DATA_W(32)) bus ();
  alu_share_arb #(.TAG_W(4), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0010: return {31'd0, $signed(a) < $signed(b)};
      4'b0011: return {31'd0, a < b};
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b1101: return $unsigned($signed(a) >>> b[4:0]);
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b1111: return b;
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic legal_f(input logic [3:0] c);
    return c inside {4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                     4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1111};
  endfunction
  always_comb bus.alu_data = alu_f(bus.alu_ctrl, bus.alu_rs1, bus.alu_op2);
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c, input logic [3:0] t);
    bus.req0_valid = v; bus.req0_rs1 = a; bus.req0_op2 = b; bus.req0_ctrl = c; bus.req0_tag = t;
  endtask
  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c, input logic [3:0] t);
    bus.req1_valid = v; bus.req1_rs1 = a; bus.req1_op2 = b; bus.req1_ctrl = c; bus.req1_tag = t;
  endtask
  // scoreboard: pop/compare the buffered response when it drains, then push any newly accepted request
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (q.size() == 0) chk("sb_underflow", 64'(q.size()), 64'd1);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_data", 64'(bus.rsp_data), 64'(e.data));
          chk("sb_id", 64'(bus.rsp_id), 64'(e.id));
          chk("sb_tag", 64'(bus.rsp_tag), 64'(e.tag));
          chk("sb_err", 64'(bus.rsp_err), 64'(e.err));
        end
      end
      if (bus.req0_valid && bus.req0_ready)
        q.push_back({legal_f(bus.req0_ctrl) ? alu_f(bus.req0_ctrl, bus.req0_rs1, bus.req0_op2) : 32'd0,
                     1'b0, bus.req0_tag, !legal_f(bus.req0_ctrl)});
      if (bus.req1_valid && bus.req1_ready)
        q.push_back({legal_f(bus.req1_ctrl) ? alu_f(bus.req1_ctrl, bus.req1_rs1, bus.req1_op2) : 32'd0,
                     1'b1, bus.req1_tag, !legal_f(bus.req1_ctrl)});
    end
  end
  initial begin
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    bus.rsp_ready = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.rsp_valid), 0);
    chk("rst_data", 64'(bus.rsp_data), 0);
    chk("rst_id", 64'(bus.rsp_id), 0);
    chk("rst_tag", 64'(bus.rsp_tag), 0);
    chk("rst_err", 64'(bus.rsp_err), 0);
    chk("idle_alu_ctrl", 64'(bus.alu_ctrl), 0);
    tick;
    tick;
    rst = 1'b0;
    set0(1, 5, 7, 4'b0000, 3);
    bus.rsp_ready = 1'b1;
    #2;
    chk("add_req0_ready", 64'(bus.req0_ready), 1);
    chk("add_req1_ready", 64'(bus.req1_ready), 0);
    tick;
    set0(0, 0, 0, 0, 0);
    chk("add_valid", 64'(bus.rsp_valid), 1);
    chk("add_data", 64'(bus.rsp_data), 12);
    chk("add_tag", 64'(bus.rsp_tag), 3);
    set0(1, 32'hF0, 32'h0F, 4'b0100, 1);
    set1(1, 10, 3, 4'b1000, 2);
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("alt_req0_ready", 64'(bus.req0_ready), 64'(i % 2 == 1));
      chk("alt_req1_ready", 64'(bus.req1_ready), 64'(i % 2 == 0));
      tick;
      chk("alt_valid", 64'(bus.rsp_valid), 1);
      chk("alt_id", 64'(bus.rsp_id), 64'(i % 2 == 0));
      chk("alt_data", 64'(bus.rsp_data), (i % 2 == 0) ? 64'd7 : 64'hFF);
    end
    set0(0, 0, 0, 0, 0);
    set1(1, 100, 1, 4'b0000, 5);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("stall_req1_ready", 64'(bus.req1_ready), 0);
      tick;
      chk("stall_valid", 64'(bus.rsp_valid), 1);
      chk("stall_data", 64'(bus.rsp_data), 64'hFF);
      chk("stall_id", 64'(bus.rsp_id), 0);
    end
    bus.rsp_ready = 1'b1;
    #2;
    chk("drain_req1_ready", 64'(bus.req1_ready), 1);
    tick;
    chk("drain_valid", 64'(bus.rsp_valid), 1);
    chk("drain_data", 64'(bus.rsp_data), 101);
    set1(1, 3, 9, 4'b1010, 7);
    #2;
    chk("ill_alu_ctrl", 64'(bus.alu_ctrl), 64'hF);
    chk("ill_alu_op2", 64'(bus.alu_op2), 0);
    chk("ill_req1_ready", 64'(bus.req1_ready), 1);
    tick;
    chk("ill_data", 64'(bus.rsp_data), 0);
    chk("ill_err", 64'(bus.rsp_err), 1);
    chk("ill_id", 64'(bus.rsp_id), 1);
    set1(1, 32'h8000_0000, 4, 4'b1101, 8);
    #2;
    chk("sra_alu_ctrl", 64'(bus.alu_ctrl), 64'hD);
    tick;
    chk("sra_data", 64'(bus.rsp_data), 64'hF800_0000);
    chk("sra_err", 64'(bus.rsp_err), 0);
    set1(0, 0, 0, 0, 0);
    set0(1, 32'hFFFF_FFFF, 1, 4'b0010, 9);
    tick;
    chk("slt_data", 64'(bus.rsp_data), 1);
    set0(1, 32'hFFFF_FFFF, 1, 4'b0011, 10);
    tick;
    chk("sltu_data", 64'(bus.rsp_data), 0);
    set0(1, 1, 33, 4'b0001, 11);
    tick;
    chk("sll_data", 64'(bus.rsp_data), 2);
    set0(0, 0, 0, 0, 0);
    bus.rsp_ready = 1'b0;
    #2;
    chk("pre_rst_valid", 64'(bus.rsp_valid), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(bus.rsp_valid), 0);
    chk("async_rst_data", 64'(bus.rsp_data), 0);
    tick;
    rst = 1'b0;
    set0(1, 1, 1, 4'b0000, 1);
    set1(1, 2, 2, 4'b0000, 2);
    bus.rsp_ready = 1'b1;
    #2;
    chk("post_rst_req0_ready", 64'(bus.req0_ready), 1);
    chk("post_rst_req1_ready", 64'(bus.req1_ready), 0);
    tick;
    chk("post_rst_id0", 64'(bus.rsp_id), 0);
    #2;
    chk("post_rst_req1_next", 64'(bus.req1_ready), 1);
    tick;
    chk("post_rst_id1", 64'(bus.rsp_id), 1);
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    tick;
    chk("final_drain_valid", 64'(bus.rsp_valid), 0);
    @(negedge clk);
    #1;
    chk("sb_leftover", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
